ifetch_unit: RTL and testbench



---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch_if.sv | 12 +
 rtl/ifetch_timeout_ctr.sv | 39 +++
 rtl/ifetch_unit.sv | 149 ++++++++++++++
 tb/tb_ifetch_unit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(3);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Instruction register payload: fetched word plus its address.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ir_t;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory read handshake between the fetch unit and memory.
interface ifetch_if;
  import ifetch_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifetch_timeout_ctr.sv
// Counts REQ cycles without ack and flags the cycle in which the limit is hit.
module ifetch_timeout_ctr
  import ifetch_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires on the cycle whose increment would reach LIMIT.
  assign expire_c_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, the IR and the imem read handshake.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch,
  input  logic            stall,
  input  logic            branch_valid,
  input  logic [XLEN-1:0] branch_target,
  ifetch_if.master        imem,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid,
  output logic            busy,
  output logic            fetch_err
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic            busy_q, busy_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] ptgt_q, ptgt_d;
  ir_t             ir_q, ir_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] tgt_c;
  logic            ctr_clr_c;
  logic            ctr_en_c;
  logic            expire_c;

  assign tgt_c = branch_target & ALIGN_MSK;

  ifetch_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_ctr (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (ctr_clr_c),
    .en_i       (ctr_en_c),
    .expire_c_o (expire_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      ptgt_q  <= '0;
      ir_q    <= '{pc: '0, instr: NOP_INSTR};
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      ptgt_q  <= ptgt_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state: start on an unstalled fetch, finish on ack or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fetch && !stall)        state_d = ST_REQ;
      ST_REQ:  if (imem.ack || expire_c)   state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    pc_d      = pc_q;
    addr_d    = addr_q;
    pend_d    = pend_q;
    ptgt_d    = ptgt_q;
    ir_d      = ir_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    ctr_clr_c = 1'b0;
    ctr_en_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A redirect in IDLE takes effect at once, including for a same-cycle fetch.
        if (branch_valid) begin
          pc_d   = tgt_c;
          pend_d = 1'b0;
        end
        if (fetch && !stall) begin
          addr_d    = pc_d;
          ctr_clr_c = 1'b1;
        end
      end
      ST_REQ: begin
        if (fetch) begin
          err_d = 1'b1;
        end
        if (imem.ack) begin
          ir_d    = '{pc: pc_q, instr: imem.rdata};
          valid_d = 1'b1;
          pend_d  = 1'b0;
          if (branch_valid) begin
            pc_d = tgt_c;
          end else if (pend_q) begin
            pc_d = ptgt_q;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end else begin
          ctr_en_c = 1'b1;
          if (branch_valid) begin
            pend_d = 1'b1;
            ptgt_d = tgt_c;
          end
          if (expire_c) begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    req_d  = (state_d == ST_REQ);
    busy_d = (state_d == ST_REQ);
  end

  assign imem.req    = req_q;
  assign imem.addr   = addr_q;
  assign instr       = ir_q.instr;
  assign pc_out      = ir_q.pc;
  assign instr_valid = valid_q;
  assign busy        = busy_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized traffic vs a reference model.
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC1 = 32'h0000_0000;
  localparam int unsigned TMO     = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch, stall, branch_valid;
  logic [31:0] branch_target;
  logic [31:0] instr, pc_out;
  logic        instr_valid, busy, fetch_err;

  logic        fetch2;
  logic        zero2;
  logic [31:0] zero32;
  logic [31:0] instr2, pc_out2;
  logic        instr_valid2, busy2, fetch_err2;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  ifetch_if imem ();
  ifetch_if imem2 ();

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RST_PC1), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .fetch(fetch), .stall(stall),
    .branch_valid(branch_valid), .branch_target(branch_target), .imem(imem),
    .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid),
    .busy(busy), .fetch_err(fetch_err)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(TMO)) dut2 (
    .clk(clk), .reset(reset), .fetch(fetch2), .stall(zero2),
    .branch_valid(zero2), .branch_target(zero32), .imem(imem2),
    .instr(instr2), .pc_out(pc_out2), .instr_valid(instr_valid2),
    .busy(busy2), .fetch_err(fetch_err2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Reference model: one fetch transaction at a time, tracked as plain variables.
  logic [31:0] m_pc, m_addr, m_ptgt, m_instr, m_pcout;
  bit          m_busy, m_pend, m_valid, m_err;
  int          m_wait;

  always @(posedge clk) begin
    logic [31:0] tgt;
    tgt = {branch_target[31:2], 2'b00};
    if (!reset) begin
      m_pc = RST_PC1; m_addr = RST_PC1; m_ptgt = '0;
      m_instr = '0; m_pcout = '0;
      m_busy = 0; m_pend = 0; m_valid = 0; m_err = 0; m_wait = 0;
    end else begin
      m_valid = 0;
      if (!m_busy) begin
        if (branch_valid) begin
          m_pc = tgt;
          m_pend = 0;
        end
        if (fetch && !stall) begin
          m_busy = 1;
          m_addr = m_pc;
          m_wait = 0;
        end
      end else begin
        if (fetch) m_err = 1;
        if (imem.ack) begin
          m_instr = imem.rdata;
          m_pcout = m_pc;
          m_valid = 1;
          if (branch_valid)  m_pc = tgt;
          else if (m_pend)   m_pc = m_ptgt;
          else               m_pc = m_pc + 32'd4;
          m_pend = 0;
          m_busy = 0;
        end else begin
          if (branch_valid) begin
            m_pend = 1;
            m_ptgt = tgt;
          end
          m_wait++;
          if (m_wait == int'(TMO)) begin
            m_busy = 0;
            m_err = 1;
          end
        end
      end
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_instr",       instr,              m_instr);
      chk("m_pc_out",      pc_out,             m_pcout);
      chk("m_instr_valid", 32'(instr_valid),   32'(m_valid));
      chk("m_busy",        32'(busy),          32'(m_busy));
      chk("m_imem_req",    32'(imem.req),      32'(m_busy));
      chk("m_imem_addr",   imem.addr,          m_addr);
      chk("m_fetch_err",   32'(fetch_err),     32'(m_err));
    end
  end

  initial begin
    reset = 1'b0; fetch = 0; stall = 0; branch_valid = 0; branch_target = '0;
    imem.ack = 0; imem.rdata = '0;
    fetch2 = 0; zero2 = 0; zero32 = '0; imem2.ack = 0; imem2.rdata = '0;
    tick(); tick();
    reset = 1'b1;
    chk_en = 1;
    at_neg();
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_req", 32'(imem.req), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    chk("rst_addr2", imem2.addr, 32'hFFFF_FFFC);

    // Wrap from the top of the address space.
    fetch2 = 1; tick(); fetch2 = 0; imem2.ack = 1; imem2.rdata = 32'h1234_5678; tick(); imem2.ack = 0;
    at_neg();
    chk("wrap_pc_out", pc_out2, 32'hFFFF_FFFC);
    chk("wrap_valid", 32'(instr_valid2), 32'h1);
    fetch2 = 1; tick(); fetch2 = 0;
    at_neg();
    chk("wrap_next_addr", imem2.addr, 32'h0);
    imem2.ack = 1; tick(); imem2.ack = 0;

    // Two zero-wait fetches.
    fetch = 1; tick(); fetch = 0;
    at_neg();
    chk("f1_req", 32'(imem.req), 32'h1);
    chk("f1_addr", imem.addr, 32'h0);
    imem.ack = 1; imem.rdata = 32'h2008_0005; tick(); imem.ack = 0;
    at_neg();
    chk("f1_valid", 32'(instr_valid), 32'h1);
    chk("f1_instr", instr, 32'h2008_0005);
    chk("f1_pc_out", pc_out, 32'h0);
    fetch = 1; tick(); fetch = 0;
    imem.ack = 1; imem.rdata = 32'h2009_000A; tick(); imem.ack = 0;
    at_neg();
    chk("f2_instr", instr, 32'h2009_000A);
    chk("f2_pc_out", pc_out, 32'h4);

    // Fetch with three wait states; address must be PC=8 and held.
    fetch = 1; tick(); fetch = 0;
    at_neg();
    chk("w_addr0", imem.addr, 32'h8);
    tick(); at_neg();
    chk("w_req1", 32'(imem.req), 32'h1);
    chk("w_addr1", imem.addr, 32'h8);
    tick(); at_neg();
    chk("w_req2", 32'(imem.req), 32'h1);
    chk("w_addr2", imem.addr, 32'h8);
    tick();
    imem.ack = 1; imem.rdata = 32'hCAFE_0008; tick(); imem.ack = 0;
    at_neg();
    chk("w_pc_out", pc_out, 32'h8);
    chk("w_valid", 32'(instr_valid), 32'h1);
    chk("w_err", 32'(fetch_err), 32'h0);
    tick(); at_neg();
    chk("w_valid_once", 32'(instr_valid), 32'h0);

    // Branch during REQ: delay slot delivered, then redirect.
    branch_valid = 1; branch_target = 32'h0000_0040; tick(); branch_valid = 0;
    fetch = 1; tick(); fetch = 0;
    branch_valid = 1; branch_target = 32'h0000_0103;
    at_neg();
    chk("b1_addr", imem.addr, 32'h40);
    tick(); branch_valid = 0;
    imem.ack = 1; imem.rdata = 32'h0BAD_0040; tick(); imem.ack = 0;
    at_neg();
    chk("b1_pc_out", pc_out, 32'h40);
    fetch = 1; tick(); fetch = 0;
    at_neg();
    chk("b1_next_addr", imem.addr, 32'h100);
    imem.ack = 1; tick(); imem.ack = 0;

    // Branch on the ack cycle.
    branch_valid = 1; branch_target = 32'h0000_0040; tick(); branch_valid = 0;
    fetch = 1; tick(); fetch = 0;
    imem.ack = 1; imem.rdata = 32'h0BAD_0041; branch_valid = 1; branch_target = 32'h0000_0103;
    tick(); imem.ack = 0; branch_valid = 0;
    at_neg();
    chk("b2_pc_out", pc_out, 32'h40);
    fetch = 1; tick(); fetch = 0;
    at_neg();
    chk("b2_next_addr", imem.addr, 32'h100);
    imem.ack = 1; tick(); imem.ack = 0;

    // Timeout: PC is now 0x104.
    fetch = 1; tick(); fetch = 0;
    repeat (TMO - 1) tick();
    at_neg();
    chk("t_req_last", 32'(imem.req), 32'h1);
    tick(); at_neg();
    chk("t_req_drop", 32'(imem.req), 32'h0);
    chk("t_err", 32'(fetch_err), 32'h1);
    chk("t_busy", 32'(busy), 32'h0);
    fetch = 1; tick(); fetch = 0;
    at_neg();
    chk("t_reissue", imem.addr, 32'h104);
    imem.ack = 1; imem.rdata = 32'h0000_0104; tick(); imem.ack = 0;
    at_neg();
    chk("t_pc_out", pc_out, 32'h104);

    // Fetch while busy.
    reset = 0; tick(); reset = 1;
    fetch = 1; tick(); tick(); fetch = 0;
    at_neg();
    chk("fb_err", 32'(fetch_err), 32'h1);
    chk("fb_busy", 32'(busy), 32'h1);
    imem.ack = 1; tick(); imem.ack = 0;

    // Stalled fetch is dropped without error.
    reset = 0; tick(); reset = 1;
    fetch = 1; stall = 1; tick(); fetch = 0; stall = 0;
    at_neg();
    chk("st_req", 32'(imem.req), 32'h0);
    chk("st_err", 32'(fetch_err), 32'h0);

    // Reset in the second REQ cycle, then a late ack.
    fetch = 1; tick(); fetch = 0;
    imem.ack = 1; imem.rdata = 32'h5555_AAAA; tick(); imem.ack = 0;
    fetch = 1; tick(); fetch = 0;
    tick();
    reset = 0; tick(); reset = 1;
    imem.ack = 1; imem.rdata = 32'h7777_7777;
    at_neg();
    chk("mr_req", 32'(imem.req), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_instr", instr, 32'h0);
    chk("mr_pc_out", pc_out, 32'h0);
    chk("mr_addr", imem.addr, 32'h0);
    tick(); imem.ack = 0;
    at_neg();
    chk("mr_late_ack", 32'(instr_valid), 32'h0);

    // Randomized traffic with periodic no-ack windows to provoke timeouts.
    for (int i = 0; i < 4000; i++) begin
      tick();
      reset         = ($urandom_range(0, 249) != 0);
      fetch         = ($urandom_range(0, 2) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_valid  = ($urandom_range(0, 5) == 0);
      branch_target = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
      imem.ack      = ((i % 400) >= 60) && ($urandom_range(0, 2) == 0);
      imem.rdata    = $urandom;
    end
    tick();
    reset = 1; fetch = 0; stall = 0; branch_valid = 0; imem.ack = 0;
    tick(); tick();
    at_neg();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
